// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add unsigned multiplier, with a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULLO = 4'b1000;
    localparam logic [3:0] OP_MULHI = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             mul_hi_q, mul_hi_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Bit 0 of the accumulator is shifted out before it is ever read,
    // so only bits [2W-1:1] are stored; the full 2W value exists in acc_step.
    logic [2*WIDTH-1:1] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     upper_sum;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             is_mul;

    assign sum    = src1_i + src2_i;
    assign diff   = src1_i - src2_i;
    assign shamt  = src2_i[SHW-1:0];
    assign is_mul = (ctrl_i == OP_MULLO) || (ctrl_i == OP_MULHI);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ctrl_i)
            OP_AND: alu_res = src1_i & src2_i;
            OP_OR:  alu_res = src1_i | src2_i;
            OP_NOR: alu_res = ~(src1_i | src2_i);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                          (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                          (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SLL: alu_res = src1_i << shamt;
            OP_SRL: alu_res = src1_i >> shamt;
            OP_SRA: alu_res = $signed(src1_i) >>> shamt;
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // One shift-add step: the upper half gets a carry bit so nothing is lost before the shift.
    always_comb begin
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_step  = {upper_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        mul_hi_d = mul_hi_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (is_mul) begin
                        state_d  = MUL;
                        mcand_d  = src1_i;
                        mplier_d = src2_i;
                        mul_hi_d = ctrl_i[0];
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step[2*WIDTH-1:1];
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = IDLE;
                    result_d = mul_hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            mul_hi_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            mul_hi_q <= mul_hi_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
        end
    end

    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q == MUL);
    assign done_o     = done_q;

endmodule
